// File: rtl/mc_control_fsm.sv
// Main multicycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional macro CTRL_TRAP_EN: illegal opcodes trap and set a sticky illegal_instr flag.
module mc_control_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               branch,
   output logic               ir_write,
   output logic               adr_src,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic [1:0]         result_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic               illegal_instr,
   output logic [STATE_W-1:0] state_o
);

   localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
   localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
   localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
   localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
   localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
   localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
   localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
   localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
   localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
   localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
   localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
   localparam logic [STATE_W-1:0] S_JALR     = STATE_W'(11);
   localparam logic [STATE_W-1:0] S_LUI      = STATE_W'(12);
   localparam logic [STATE_W-1:0] S_AUIPC    = STATE_W'(13);
   localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(14);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] next_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_FETCH:    if (mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_R:              next_state = S_EXECR;
               OP_I:              next_state = S_EXECI;
               OP_BR:             next_state = S_BRANCH;
               OP_JAL:            next_state = S_JAL;
               OP_JALR:           next_state = S_JALR;
               OP_LUI:            next_state = S_LUI;
               OP_AUIPC:          next_state = S_AUIPC;
`ifdef CTRL_TRAP_EN
               default:           next_state = S_TRAP;
`else
               default:           next_state = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
         S_MEMWB:    next_state = S_FETCH;
         S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
         S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: next_state = S_ALUWB;
         S_ALUWB, S_BRANCH: next_state = S_FETCH;
         S_JALR:     next_state = S_JAL;
`ifdef CTRL_TRAP_EN
         S_TRAP:     next_state = S_TRAP;
`endif
         default:    next_state = S_FETCH;
      endcase
   end

   // Outputs decode from state; held at zero while reset is asserted so an aborted access writes nothing.
   always_comb begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  alu_src_b  = 2'b10;
                  result_src = 2'b10;
               end
            end
            S_DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
            end
            S_MEMADR, S_JALR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
               adr_src  = 1'b1;
               mem_read = 1'b1;
            end
            S_MEMWB: begin
               result_src = 2'b01;
               reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
               adr_src   = 1'b1;
               mem_write = 1'b1;
            end
            S_EXECR: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b10;
            end
            S_EXECI: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_op    = 2'b10;
            end
            S_ALUWB:  reg_write = 1'b1;
            S_BRANCH: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b01;
               branch    = 1'b1;
            end
            S_JAL: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
               pc_write  = 1'b1;
            end
            S_LUI: begin
               alu_src_a = 2'b11;
               alu_src_b = 2'b01;
            end
            S_AUIPC: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
            end
            default: ;
         endcase
      end
   end

`ifdef CTRL_TRAP_EN
   // TRAP is absorbing until reset, so the flag is sticky by construction.
   assign illegal_instr = !rst && (state == S_TRAP);
`else
   assign illegal_instr = 1'b0;
`endif

   assign state_o = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: reset/corner sequences, latency table, randomized model run.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic       illegal_instr;
   logic [3:0] state_o;

   int n_vec = 0;
   int n_bad = 0;

   mc_control_fsm #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .branch(branch), .ir_write(ir_write), .adr_src(adr_src),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .illegal_instr(illegal_instr), .state_o(state_o)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                          JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

   function automatic logic [14:0] outs();
      return {pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write,
              result_src, alu_src_a, alu_src_b, alu_op};
   endfunction

   function automatic logic [14:0] mk(bit pcw, bit br, bit irw, bit adr, bit mr, bit mw,
                                      bit rw, logic [1:0] rs, logic [1:0] a,
                                      logic [1:0] b, logic [1:0] op);
      return {pcw, br, irw, adr, mr, mw, rw, rs, a, b, op};
   endfunction

   // Expected control word for each step of an instruction, straight from the step descriptions.
   function automatic logic [14:0] exp_word(int s, bit rdy);
      case (s)
         0:  return rdy ? mk(1,0,1,0,1,0,0,2'b10,2'b00,2'b10,2'b00)
                        : mk(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00);
         1:  return mk(0,0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00);
         2:  return mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00);
         3:  return mk(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00);
         4:  return mk(0,0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00);
         5:  return mk(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00);
         6:  return mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10);
         7:  return mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10);
         8:  return mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00);
         9:  return mk(0,1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01);
         10: return mk(1,0,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00);
         11: return mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00);
         12: return mk(0,0,0,0,0,0,0,2'b00,2'b11,2'b01,2'b00);
         13: return mk(0,0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00);
         default: return 15'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input bit rdy);
      @(negedge clk);
      mem_ready = rdy;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b0;
      #1;
      check("reset_state", state_o, 0);
      check("reset_outs", {outs(), illegal_instr}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   typedef struct {
      logic [6:0] op;
      int lat, n_rw, n_pcw, n_mw, n_br;
   } lat_rec_t;

   int seq[$];

   task automatic build(input logic [6:0] op);
      case (op)
         LOAD:  seq = '{0, 1, 2, 3, 4};
         STORE: seq = '{0, 1, 2, 5};
         RT:    seq = '{0, 1, 6, 8};
         IT:    seq = '{0, 1, 7, 8};
         BR:    seq = '{0, 1, 9};
         JAL:   seq = '{0, 1, 10, 8};
         JALR:  seq = '{0, 1, 11, 10, 8};
         LUI:   seq = '{0, 1, 12, 8};
         AUIPC: seq = '{0, 1, 13, 8};
`ifdef CTRL_TRAP_EN
         default: seq = '{0, 1, 14};
`else
         default: seq = '{0, 1};
`endif
      endcase
   endtask

   initial begin
      lat_rec_t tbl[$];
      logic [6:0] pool[$];
      int cyc, rw, pcw, mw, br, cnt, adr_all;

      // Reset state at time zero.
      #1;
      check("init_state", state_o, 0);
      check("init_outs", {outs(), illegal_instr}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Asynchronous reset in the middle of a stalled load.
      opcode = LOAD;
      mem_ready = 1'b1;
      tick(1);
      tick(1);
      tick(0);
      check("memread_entry", state_o, 3);
      tick(0);
      check("memread_stall", {state_o, outs()}, {4'd3, exp_word(3, 0)});
      #1 rst = 1'b1;
      #1;
      check("async_rst_state", state_o, 0);
      check("async_rst_outs", {outs(), illegal_instr}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_fetch", {state_o, outs()}, {4'd0, exp_word(0, 0)});

      // Fetch stalled three cycles.
      do_reset();
      opcode = RT;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick(0);
         cnt += int'(ir_write) + int'(pc_write);
         check("fetch_stall_state", state_o, 0);
      end
      check("fetch_stall_strobes", cnt, 0);
      tick(1);
      check("fetch_ready_strobes", {ir_write, pc_write}, 2'b11);
      tick(0);
      check("fetch_to_decode", state_o, 1);

      // Store with two stall cycles in MEMWRITE.
      do_reset();
      opcode = STORE;
      mem_ready = 1'b1;
      tick(1);
      tick(1);
      tick(0);
      cnt = 0;
      adr_all = 1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) tick(0);
         if (i == 2) tick(1);
         cnt += int'(mem_write);
         if (!adr_src || state_o != 4'd5) adr_all = 0;
      end
      check("store_mw_cycles", cnt, 3);
      check("store_adr_src", adr_all, 1);
      tick(1);
      check("store_to_fetch", state_o, 0);

      // Illegal opcode.
      do_reset();
      opcode = 7'b1111111;
      mem_ready = 1'b1;
      tick(1);
      tick(1);
`ifdef CTRL_TRAP_EN
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (state_o == 4'd14 && illegal_instr && outs() == 15'd0) cnt++;
         tick($urandom_range(0, 1));
      end
      check("trap_hold_cycles", cnt, 12);
`else
      check("illegal_nop", {state_o, illegal_instr}, {4'd0, 1'b0});
`endif

      // Latency table with mem_ready tied high.
      tbl.push_back('{LOAD, 5, 1, 1, 0, 0});
      tbl.push_back('{STORE, 4, 0, 1, 1, 0});
      tbl.push_back('{RT, 4, 1, 1, 0, 0});
      tbl.push_back('{IT, 4, 1, 1, 0, 0});
      tbl.push_back('{LUI, 4, 1, 1, 0, 0});
      tbl.push_back('{AUIPC, 4, 1, 1, 0, 0});
      tbl.push_back('{BR, 3, 0, 1, 0, 1});
      tbl.push_back('{JAL, 4, 1, 2, 0, 0});
      tbl.push_back('{JALR, 5, 1, 2, 0, 0});
`ifndef CTRL_TRAP_EN
      tbl.push_back('{7'b1111111, 2, 0, 1, 0, 0});
`endif
      do_reset();
      mem_ready = 1'b1;
      for (int k = 0; k < tbl.size(); k++) begin
         opcode = tbl[k].op;
         #1;
         cyc = 0; rw = 0; pcw = 0; mw = 0; br = 0;
         do begin
            rw += int'(reg_write); pcw += int'(pc_write);
            mw += int'(mem_write); br += int'(branch);
            cyc++;
            tick(1);
         end while (state_o != 4'd0 && cyc < 20);
         check($sformatf("latency_%b", tbl[k].op),
               {cyc[7:0], rw[3:0], pcw[3:0], mw[3:0], br[3:0]},
               {tbl[k].lat[7:0], tbl[k].n_rw[3:0], tbl[k].n_pcw[3:0],
                tbl[k].n_mw[3:0], tbl[k].n_br[3:0]});
      end

      // Randomized run against the step-sequence model.
      pool = '{LOAD, STORE, RT, IT, BR, JAL, JALR, LUI, AUIPC};
`ifndef CTRL_TRAP_EN
      pool.push_back(7'b0000000);
      pool.push_back(7'b1110011);
`endif
      do_reset();
      seq.delete();
      for (int n = 0; n < 800; n++) begin
         bit rdy;
         int h;
         if (seq.size() == 0) begin
            opcode = pool[$urandom_range(0, pool.size() - 1)];
            build(opcode);
         end
         h = seq[0];
         rdy = ($urandom_range(0, 3) != 0);
         mem_ready = rdy;
         #1;
         check("rand_step", {state_o, outs(), illegal_instr},
               {h[3:0], exp_word(h, rdy), (h == 14)});
         if (!(((h == 0) || (h == 3) || (h == 5)) && !rdy) && h != 14)
            void'(seq.pop_front());
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
